// File: rtl/div_ratio_detector_if.sv
// rtl/div_ratio_detector_if.sv - signal bundle between a divided-clock source and its ratio detector
//
// Purpose: carries the divided signal into the detector and the measurement results back out.
// Signals:
//    sig_in     divided signal, synchronous to the detector clock
//    period     last rising-to-rising interval in clock cycles
//    high_time  clock cycles sig_in was high within that interval
//    valid      one-cycle pulse when period/high_time update
//    locked     level, ratio stable
//    err        one-cycle pulse, period changed while locked
//    timeout    one-cycle pulse, no rising edge for 2^CNT_W-1 cycles
// Modports:
//    master     detector side (samples sig_in, drives results)
//    slave      source/observer side (drives sig_in, reads results)
interface div_ratio_detector_if #(
   parameter int CNT_W = 8
);
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             locked;
   logic             err;
   logic             timeout;

   modport master (
      input  sig_in,
      output period, high_time, valid, locked, err, timeout
   );

   modport slave (
      output sig_in,
      input  period, high_time, valid, locked, err, timeout
   );
endinterface

// File: rtl/div_ratio_detector.sv
// rtl/div_ratio_detector.sv - measures period and high time of a divided clock and tracks ratio lock
//
// Purpose: samples sig_in in the clk domain, measures each rising-to-rising interval and the
// number of high samples in it, declares lock after LOCK_CNT consecutive identical periods
// following a reference capture, and flags ratio changes and loss of signal.
// Ports:
//    clk   system clock, all logic on the rising edge
//    rst   synchronous active-low reset
//    bus   div_ratio_detector_if.master (sig_in in; period, high_time, valid, locked, err, timeout out)
module div_ratio_detector #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4
) (
   input logic                clk,
   input logic                rst,
   div_ratio_detector_if.master bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int               MW      = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

   state_t           state, state_nxt;
   logic             sig_d;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hacc;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_q;
   logic             valid_q, locked_q, err_q, timeout_q;
   logic [MW-1:0]    match, match_nxt;
   logic             have_cap, have_cap_nxt;
   logic             locked_nxt, err_nxt, timeout_nxt, capture;

   assign rise = bus.sig_in & ~sig_d;

   always_comb begin
      state_nxt    = state;
      match_nxt    = match;
      have_cap_nxt = have_cap;
      locked_nxt   = locked_q;
      err_nxt      = 1'b0;
      timeout_nxt  = 1'b0;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            // First rise after idle only starts the interval; nothing to capture yet.
            if (rise) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (rise) begin
               capture      = 1'b1;
               have_cap_nxt = 1'b1;
               // The very first capture has no reference to compare against.
               if (have_cap && cnt == period_q) match_nxt = match + 1'b1;
               else                             match_nxt = '0;
               if (match_nxt == MW'(LOCK_CNT)) begin
                  state_nxt  = LOCKED;
                  locked_nxt = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (rise) begin
               capture = 1'b1;
               // A differing period drops lock and becomes the new reference.
               if (cnt != period_q) begin
                  err_nxt    = 1'b1;
                  locked_nxt = 1'b0;
                  match_nxt  = '0;
                  state_nxt  = MEASURE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Saturated counter without a rise this cycle means the signal is gone.
      // A rise in the same cycle takes precedence and captures the full-scale period.
      if (state != IDLE && !rise && cnt == CNT_MAX) begin
         timeout_nxt  = 1'b1;
         locked_nxt   = 1'b0;
         match_nxt    = '0;
         have_cap_nxt = 1'b0;
         state_nxt    = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         sig_d     <= 1'b1;   // a level already high out of reset is not an edge
         cnt       <= '0;
         hacc      <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         match     <= '0;
         have_cap  <= 1'b0;
      end else begin
         state     <= state_nxt;
         sig_d     <= bus.sig_in;
         match     <= match_nxt;
         have_cap  <= have_cap_nxt;
         valid_q   <= capture;
         locked_q  <= locked_nxt;
         err_q     <= err_nxt;
         timeout_q <= timeout_nxt;
         if (capture) begin
            period_q <= cnt;
            high_q   <= hacc;
         end
         if (rise) begin
            cnt  <= CNT_W'(1);
            hacc <= CNT_W'(1);
         end else begin
            if (cnt != CNT_MAX)                  cnt  <= cnt + 1'b1;
            if (bus.sig_in && hacc != CNT_MAX)   hacc <= hacc + 1'b1;
         end
      end
   end

   assign bus.period    = period_q;
   assign bus.high_time = high_q;
   assign bus.valid     = valid_q;
   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.timeout   = timeout_q;
endmodule
